// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - MIPS-style coprocessor 0: Count/Compare timer, Status/Cause/EPC, exception and ERET handling
module cp0_ctrl #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] STATUS_RESET = 32'h1040FF00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [4:0]            raddr,
  input  logic [31:0]           wdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badva,
  input  logic                  eret,
  output logic [31:0]           rdata,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic [31:0]           epc,
  output logic                  int_req
);

  // Status bits software may change: IM[15:8], EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;

  logic [31:0] count_q, compare_q, status_q, status_n, epc_q, badva_q;
  logic [4:0]  presc_q;
  logic [4:0]  exccode_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic        ti_q, bd_q, iv_q;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = we && (waddr == 5'd9);
  assign wr_compare = we && (waddr == 5'd11);
  assign wr_status  = we && (waddr == 5'd12);
  assign wr_cause   = we && (waddr == 5'd13);
  assign wr_epc     = we && (waddr == 5'd14);

  // Exception sets EXL and outranks ERET; both outrank an MTC0 to Status
  always_comb begin
    status_n = status_q;
    if (wr_status)
      status_n = (wdata & STATUS_WMASK) | (STATUS_RESET & ~STATUS_WMASK);
    if (exc_valid)
      status_n[1] = 1'b1;
    else if (eret)
      status_n[1] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      presc_q   <= '0;
      ti_q      <= 1'b0;
      ip_hw_q   <= '0;
      ip_sw_q   <= '0;
      iv_q      <= 1'b0;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      status_q  <= STATUS_RESET;
      epc_q     <= '0;
      badva_q   <= '0;
    end else begin
      if (wr_count) begin
        count_q <= wdata;
        presc_q <= '0;
      end else if (presc_q == 5'(COUNT_DIV - 1)) begin
        count_q <= count_q + 32'd1;
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 5'd1;
      end

      if (wr_compare) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end

      ip_hw_q <= 6'(hw_int);

      if (wr_cause) begin
        iv_q    <= wdata[23];
        ip_sw_q <= wdata[9:8];
      end

      status_q <= status_n;

      // A nested exception (EXL already set) keeps the original EPC/BD
      if (exc_valid) begin
        exccode_q <= exc_code;
        if (!status_q[1]) begin
          epc_q <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          bd_q  <= exc_bd;
        end
        if (exc_code == 5'd4 || exc_code == 5'd5)
          badva_q <= exc_badva;
      end else if (wr_epc) begin
        epc_q <= wdata;
      end
    end
  end

  assign cause = {bd_q, ti_q, 6'b0, iv_q, 7'b0, ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                  ip_sw_q, 1'b0, exccode_q, 2'b0};
  assign status = status_q;
  assign epc    = epc_q;

  assign int_req = status_q[0] & ~status_q[1] & (|(cause[15:8] & status_q[15:8]));

  always_comb begin
    rdata = '0;
    case (raddr)
      5'd8:    rdata = badva_q;
      5'd9:    rdata = count_q;
      5'd11:   rdata = compare_q;
      5'd12:   rdata = status_q;
      5'd13:   rdata = cause;
      5'd14:   rdata = epc_q;
      5'd15:   rdata = PRID_VALUE;
      5'd16:   rdata = 32'h00008000;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - directed and randomized checks of cp0_ctrl against a behavioural model
module tb_cp0_ctrl;

  localparam int          DIV    = 2;
  localparam logic [31:0] ST_RST = 32'h1040FF00;
  localparam logic [31:0] PRID   = 32'h004C0102;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [5:0]  hw_int = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badva = '0;
  logic        eret = 1'b0;

  logic [31:0] rdata, status, cause, epc;
  logic        int_req;
  logic [31:0] rdata2, status2, cause2, epc2;
  logic        int_req2;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_count, m_compare, m_status, m_epc, m_badva;
  int          m_presc;
  logic        m_ti, m_bd, m_iv;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_hw;
  logic [4:0]  m_exccode;

  always #5 clk = ~clk;

  cp0_ctrl #(.NUM_HW_INT(6), .COUNT_DIV(DIV)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .raddr(raddr), .wdata(wdata),
    .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badva(exc_badva), .eret(eret),
    .rdata(rdata), .status(status), .cause(cause), .epc(epc), .int_req(int_req)
  );

  cp0_ctrl #(.NUM_HW_INT(2), .COUNT_DIV(3)) u_dut2 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .raddr(raddr), .wdata(wdata),
    .hw_int(hw_int[1:0]), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badva(exc_badva), .eret(eret),
    .rdata(rdata2), .status(status2), .cause(cause2), .epc(epc2), .int_req(int_req2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 6'b0, m_iv, 7'b0, m_hw[5] | m_ti, m_hw[4:0], m_ipsw, 1'b0, m_exccode, 2'b0};
  endfunction

  function automatic logic m_int();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return 32'h00008000;
      default: return 32'h0;
    endcase
  endfunction

  // Apply one clock edge of architectural behaviour to the model
  task automatic model_edge();
    logic was_exl;
    if (rst) begin
      m_count = 0; m_compare = 0; m_presc = 0; m_ti = 0; m_status = ST_RST;
      m_epc = 0; m_badva = 0; m_bd = 0; m_iv = 0; m_ipsw = 0; m_hw = 0; m_exccode = 0;
      return;
    end
    was_exl = m_status[1];
    if (we && waddr == 11) begin
      m_compare = wdata; m_ti = 0;
    end else if (m_count == m_compare) m_ti = 1;
    if (we && waddr == 9) begin
      m_count = wdata; m_presc = 0;
    end else begin
      m_presc = (m_presc + 1) % DIV;
      if (m_presc == 0) m_count = m_count + 1;
    end
    m_hw = hw_int;
    if (we && waddr == 13) begin m_iv = wdata[23]; m_ipsw = wdata[9:8]; end
    if (we && waddr == 12) m_status = (wdata & 32'h0000FF03) | (ST_RST & 32'hFFFF00FC);
    if (exc_valid) begin
      m_exccode = exc_code;
      m_status[1] = 1;
      if (!was_exl) begin
        m_epc = exc_bd ? exc_pc - 4 : exc_pc;
        m_bd = exc_bd;
      end
      if (exc_code == 4 || exc_code == 5) m_badva = exc_badva;
    end else begin
      if (eret) m_status[1] = 0;
      if (we && waddr == 14) m_epc = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("status", status, m_status);
    check("cause", cause, m_cause());
    check("epc", epc, m_epc);
    check("int_req", {31'b0, int_req}, {31'b0, m_int()});
    raddr = 5'($urandom_range(0, 20));
    #1;
    check("rdata", rdata, m_read(raddr));
  endtask

  task automatic idle();
    rst = 0; we = 0; exc_valid = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr = a; #1;
    check(tag, rdata, exp);
  endtask

  task automatic peek2(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr = a; #1;
    check(tag, rdata2, exp);
  endtask

  initial begin
    // reset state
    rst = 1; tick(); idle();
    check("rst_status", status, ST_RST);
    check("rst_cause", cause, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    peek("rst_count", 9, 32'h0);
    peek("prid", 15, PRID);
    peek("config", 16, 32'h00008000);

    // Count rate and wrap
    repeat (10) tick();
    peek("count_10clk", 9, 32'd5);
    mtc0(9, 32'hFFFFFFFF);
    repeat (2) tick();
    peek("count_wrap", 9, 32'd0);

    // timer interrupt; Compare write during the match cycle keeps TI clear
    mtc0(11, 32'd8);
    mtc0(12, 32'h00008001);
    check("status_wr", status, 32'h10408001);
    mtc0(9, 32'd0);
    repeat (16) tick();
    peek("count_at_8", 9, 32'd8);
    check("ti_before", {31'b0, cause[30]}, 32'h0);
    tick();
    check("ti_set", {31'b0, cause[30]}, 32'h1);
    check("int_req_ti", {31'b0, int_req}, 32'h1);
    mtc0(11, 32'd100);
    check("ti_clear", {31'b0, cause[30]}, 32'h0);
    check("int_req_clear", {31'b0, int_req}, 32'h0);

    // address error in a delay slot
    idle(); exc_valid = 1; exc_code = 4; exc_pc = 32'hBFC00100; exc_bd = 1; exc_badva = 32'h3;
    tick(); idle();
    check("exc_epc", epc, 32'hBFC000FC);
    check("exc_bd", {31'b0, cause[31]}, 32'h1);
    check("exc_code", {27'b0, cause[6:2]}, 32'd4);
    check("exc_exl", {31'b0, status[1]}, 32'h1);
    check("exc_int_req", {31'b0, int_req}, 32'h0);
    peek("exc_badva", 8, 32'h3);

    // nested exception, then ERET
    exc_valid = 1; exc_code = 8; exc_pc = 32'h80001000; exc_bd = 0; exc_badva = 32'h55;
    tick(); idle();
    check("nest_epc", epc, 32'hBFC000FC);
    check("nest_code", {27'b0, cause[6:2]}, 32'd8);
    peek("nest_badva", 8, 32'h3);
    eret = 1; tick(); idle();
    check("eret_exl", {31'b0, status[1]}, 32'h0);

    // same-cycle priority
    exc_valid = 1; exc_code = 10; exc_pc = 32'h00400020; exc_bd = 0;
    we = 1; waddr = 12; wdata = 32'h0;
    tick(); idle();
    check("prio_exc_status", status, 32'h10400002);
    eret = 1; we = 1; waddr = 14; wdata = 32'h1234;
    tick(); idle();
    check("prio_eret_exl", {31'b0, status[1]}, 32'h0);
    check("prio_eret_epc", epc, 32'h1234);

    // narrow hardware interrupt configuration, then mid-run reset
    mtc0(11, 32'hFFFF0000);
    mtc0(12, 32'h00000801);
    hw_int = 6'b111110;
    repeat (2) tick();
    check("hw2_ip", {26'b0, cause2[15:10]}, 32'b000010);
    check("hw2_int_req", {31'b0, int_req2}, 32'h1);
    check("hw6_ip", {26'b0, cause[15:10]}, 32'b111110);
    rst = 1; hw_int = 0; we = 1; waddr = 14; wdata = 32'hDEAD; exc_valid = 1; eret = 1;
    tick(); idle();
    check("rst2_status", status2, ST_RST);
    check("rst2_cause", cause2, 32'h0);
    check("rst2_epc", epc2, 32'h0);
    check("rst2_int_req", {31'b0, int_req2}, 32'h0);
    peek2("rst2_count", 9, 32'h0);
    peek2("rst2_compare", 11, 32'h0);
    peek2("rst2_badva", 8, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      idle();
      rst       = ($urandom_range(0, 59) == 0);
      we        = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 8))
        0: waddr = 8;  1: waddr = 9;  2: waddr = 11; 3: waddr = 12;
        4: waddr = 13; 5: waddr = 14; 6: waddr = 15; 7: waddr = 16;
        default: waddr = 5'($urandom);
      endcase
      wdata = $urandom;
      if (waddr == 11 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(0, 4);
      if (waddr == 9 && $urandom_range(0, 1) == 1) wdata = m_compare - $urandom_range(0, 4);
      hw_int    = 6'($urandom);
      exc_valid = ($urandom_range(0, 7) == 0);
      exc_code  = ($urandom_range(0, 2) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
      exc_pc    = $urandom;
      exc_bd    = 1'($urandom);
      exc_badva = $urandom;
      eret      = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter NUM_HW_INT, default 6, number of hardware interrupt lines (legal 1..6).
REQ-002 Parameter COUNT_DIV, default 2, Count increments once per COUNT_DIV clocks (legal 1..16).
REQ-003 Parameter PRID_VALUE, default 32'h004C0102, read-only PRId contents.
REQ-004 Parameter STATUS_RESET, default 32'h1040FF00, Status value after reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 we  input  1  MTC0 write strobe.
REQ-008 waddr  input  5  CP0 register number for write.
REQ-009 raddr  input  5  CP0 register number for read.
REQ-010 wdata  input  32  MTC0 write data.
REQ-011 hw_int  input  NUM_HW_INT  level-sensitive external interrupt lines.
REQ-012 exc_valid  input  1  exception commit strobe from MEM stage.
REQ-013 exc_code  input  5  ExcCode of the committed exception.
REQ-014 exc_pc  input  32  PC of the faulting instruction.
REQ-015 exc_bd  input  1  faulting instruction is in a delay slot.
REQ-016 exc_badva  input  32  faulting address for AdEL/AdES.
REQ-017 eret  input  1  ERET commit strobe.
REQ-018 rdata  output  32  combinational read of register raddr.
REQ-019 status  output  32  current Status.
REQ-020 cause  output  32  current Cause.
REQ-021 epc  output  32  current EPC.
REQ-022 int_req  output  1  interrupt pending and enabled.

Function
REQ-023 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15), Config(16); other addresses read 0, writes ignored.
REQ-024 Prescaler counts 0..COUNT_DIV-1; Count += 1 (mod 2^32) on the cycle prescaler equals COUNT_DIV-1; prescaler wraps to 0.
REQ-025 MTC0 to Count loads wdata and clears prescaler; Count does not also increment that cycle.
REQ-026 Cause.TI (bit 30) set in the cycle after Count equals Compare (sampled before update); stays set until MTC0 to Compare, which clears TI and loads Compare; a compare write in the match cycle wins (TI stays 0).
REQ-027 Cause.IP[7:2] (bits 15:10) sampled each cycle: bit 10+i = hw_int[i] for i < NUM_HW_INT, else 0; bit 15 additionally ORed with TI.
REQ-028 MTC0 to Cause writes only IP[1:0] (bits 9:8) and IV (bit 23); all other Cause bits read-only.
REQ-029 MTC0 to Status writes bits IM[15:8], EXL[1], IE[0]; bit 22 (BEV) and all other bits hold STATUS_RESET values.
REQ-030 MTC0 to EPC loads wdata; MTC0 to BadVAddr, PRId, Config ignored.
REQ-031 exc_valid with Status.EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; Cause.BD <= exc_bd; Cause.ExcCode[6:2] <= exc_code; Status.EXL <= 1.
REQ-032 exc_valid with Status.EXL=1: EPC and Cause.BD unchanged; ExcCode still updated; EXL stays 1.
REQ-033 exc_code 4 or 5 (AdEL/AdES): BadVAddr <= exc_badva; other codes leave BadVAddr unchanged.
REQ-034 eret (exc_valid=0): Status.EXL <= 0.
REQ-035 Same-cycle priority: exc_valid > eret > MTC0 for every field both touch; non-conflicting MTC0 fields still written.
REQ-036 int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]), combinational from registered state.
REQ-037 rdata reflects register state before the current edge (no write-to-read bypass); Config reads 32'h00008000.

Reset
REQ-038 On rst: Count, Compare, Cause, EPC, BadVAddr, prescaler = 0; Status = STATUS_RESET; int_req = 0; rdata follows raddr normally.
REQ-039 rst overrides all same-cycle writes, exceptions and ERET; asserting rst mid-operation discards pending TI and prescaler phase.

Verification
REQ-040 COUNT_DIV=2, reset, run 10 clocks -> Count reads 5; MTC0 Count=32'hFFFFFFFF then 2 clocks -> Count 0 (wrap).
REQ-041 Compare=8, Status=32'h00008001 -> TI=1 and int_req=1 one cycle after Count hits 8; MTC0 Compare=100 -> TI=0, int_req=0 next cycle.
REQ-042 exc_valid, code 4, exc_pc=32'hBFC00100, exc_bd=1, badva=32'h3 -> EPC=32'hBFC000FC, Cause.BD=1, ExcCode=4, BadVAddr=3, EXL=1, int_req=0.
REQ-043 Second exception code 8 while EXL=1 -> EPC unchanged, ExcCode=8; then eret -> EXL=0.
REQ-044 Same cycle exc_valid (code 10) and MTC0 Status=0 -> EXL=1, IE=0, IM=0; same cycle eret and MTC0 EPC=32'h1234 -> EXL=0, EPC=32'h1234.
REQ-045 NUM_HW_INT=2, hw_int=2'b10, Status IM[3]=1, IE=1 -> Cause bit 11=1, bits 15:12=0, int_req=1; rst mid-sequence -> all REQ-038 values.
